// File: rtl/char_fetch_sequencer.sv
// Text-mode glyph fetcher: walks the cells of a text row, reads the character code and then its
// glyph row byte, and serialises the bytes into one pixel bit per active pixel strobe.
// Latency: first glyph byte 4 clocks after lineStart, shifter loaded 1 clock later; pixel out 1 clock after pixEn.
// Backpressure: one cell is prefetched ahead. The fetcher stalls in FULL until the shifter takes the cell; pixels are never stalled.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   lineStart, lineIdx    line start pulse and pixel line number of the upcoming line
//   pixEn, activeEn       pixel strobe and active-video qualifier
//   txtRdEn/txtAddr/txtData  text RAM read port (data one clock after the strobe)
//   romRdEn/romAddr/romData  char ROM read port, address {code, glyphRow} (data one clock after the strobe)
//   outBit, outValid      registered pixel bit and its one-clock valid pulse
//   underrun              sticky flag: an active pixel found no glyph data while cells remained

module char_fetch_sequencer #(
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int GLYPH_H = 16,
    parameter int CODE_W  = 8,
    parameter int TXT_AW  = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                lineStart,
    input  logic [8:0]          lineIdx,
    input  logic                pixEn,
    input  logic                activeEn,
    output logic                txtRdEn,
    output logic [TXT_AW-1:0]   txtAddr,
    input  logic [CODE_W-1:0]   txtData,
    output logic                romRdEn,
    output logic [CODE_W+3:0]   romAddr,
    input  logic [7:0]          romData,
    output logic                outBit,
    output logic                outValid,
    output logic                underrun
);

    localparam int COL_W = $clog2(COLS);
    localparam int LINES = ROWS * GLYPH_H;

    typedef enum logic [2:0] {
        IDLE,
        TXT_REQ,
        TXT_LAT,
        ROM_REQ,
        ROM_LAT,
        FULL
    } state_t;

    state_t state;
    state_t stateNext;

    logic [COL_W-1:0]  col;
    logic [TXT_AW-1:0] base;
    logic [3:0]        glyphRow;
    logic [CODE_W-1:0] code;
    logic [7:0]        nextByte;
    logic [7:0]        curByte;
    logic              nextValid;
    logic              curValid;
    logic [2:0]        bitCnt;

    // Values captured at line start.
    logic              lineBlank;
    logic [TXT_AW-1:0] lsBase;
    logic [3:0]        lsGlyph;

    assign lineBlank = (lineIdx >= 9'(LINES));
    assign lsBase    = TXT_AW'(lineIdx / 9'(GLYPH_H)) * TXT_AW'(COLS);
    assign lsGlyph   = 4'(lineIdx % 9'(GLYPH_H));

    logic lastCol;
    logic consume;
    logic advance;
    logic cellsRemain;

    assign lastCol = (col == COL_W'(COLS - 1));
    assign consume = pixEn & activeEn;
    // FULL leaves once the shifter has taken the prefetched cell.
    assign advance = (state == FULL) && !nextValid;
    // The fetcher only idles before a line, on a blank line, or after the last cell was
    // handed over; any other time an empty shifter means the fetch fell behind.
    assign cellsRemain = (state != IDLE) || nextValid;

    // Fetch FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Fetch FSM: next state and read strobes
    always_comb begin
        stateNext = state;
        txtRdEn   = 1'b0;
        txtAddr   = '0;
        romRdEn   = 1'b0;
        romAddr   = '0;
        case (state)
            IDLE: begin
                stateNext = IDLE;
            end
            TXT_REQ: begin
                txtRdEn   = 1'b1;
                txtAddr   = base + TXT_AW'(col);
                stateNext = TXT_LAT;
            end
            TXT_LAT: begin
                stateNext = ROM_REQ;
            end
            ROM_REQ: begin
                romRdEn   = 1'b1;
                romAddr   = {code, glyphRow};
                stateNext = ROM_LAT;
            end
            ROM_LAT: begin
                stateNext = FULL;
            end
            FULL: begin
                if (!nextValid) begin
                    stateNext = lastCol ? IDLE : TXT_REQ;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        // A new line aborts whatever is in flight; its pending response is never latched
        // because the FSM is no longer in a latch state when it arrives.
        if (lineStart) begin
            stateNext = lineBlank ? IDLE : TXT_REQ;
        end
    end

    // Fetch datapath: cell position and character code
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col      <= '0;
            base     <= '0;
            glyphRow <= '0;
            code     <= '0;
        end else if (lineStart) begin
            col      <= '0;
            base     <= lsBase;
            glyphRow <= lsGlyph;
        end else begin
            if (state == TXT_LAT) begin
                code <= txtData;
            end
            if (advance && !lastCol) begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Prefetch buffer, shifter and pixel output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nextByte  <= '0;
            nextValid <= 1'b0;
            curByte   <= '0;
            curValid  <= 1'b0;
            bitCnt    <= '0;
            outBit    <= 1'b0;
            outValid  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            outValid <= consume;
            // Bit 7 is the leftmost pixel, so bit index 7-bitCnt is simply ~bitCnt.
            outBit   <= consume & curValid & curByte[~bitCnt];
            if (consume && !curValid && cellsRemain) begin
                underrun <= 1'b1;
            end

            if (lineStart) begin
                curValid  <= 1'b0;
                nextValid <= 1'b0;
                bitCnt    <= '0;
            end else begin
                if (consume && curValid) begin
                    bitCnt <= bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        // Cell boundary: chain straight into the prefetched cell if there is one.
                        if (nextValid) begin
                            curByte   <= nextByte;
                            nextValid <= 1'b0;
                        end else begin
                            curValid <= 1'b0;
                        end
                    end
                end else if (nextValid && !curValid) begin
                    curByte   <= nextByte;
                    curValid  <= 1'b1;
                    bitCnt    <= '0;
                    nextValid <= 1'b0;
                end
                // ROM_LAT is only reached with nextValid clear, so this never races the loads above.
                if (state == ROM_LAT) begin
                    nextByte  <= romData;
                    nextValid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_char_fetch_sequencer.sv
// Bench for char_fetch_sequencer: random text/ROM contents, random pixel rates and line
// numbers, checked against a per-line model of the expected read addresses and pixel stream.
// Covers bit order, address formation, full rate, blank lines, underrun, abort and reset.

module tb_char_fetch_sequencer;

    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int GLYPH_H = 16;
    localparam int CODE_W  = 8;
    localparam int TXT_AW  = 12;
    localparam int LINES   = ROWS * GLYPH_H;

    logic                clock = 1'b0;
    logic                reset;
    logic                lineStart;
    logic [8:0]          lineIdx;
    logic                pixEn;
    logic                activeEn;
    logic                txtRdEn;
    logic [TXT_AW-1:0]   txtAddr;
    logic [CODE_W-1:0]   txtData;
    logic                romRdEn;
    logic [CODE_W+3:0]   romAddr;
    logic [7:0]          romData;
    logic                outBit;
    logic                outValid;
    logic                underrun;

    char_fetch_sequencer #(
        .COLS(COLS), .ROWS(ROWS), .GLYPH_H(GLYPH_H), .CODE_W(CODE_W), .TXT_AW(TXT_AW)
    ) dut (
        .clock(clock), .reset(reset), .lineStart(lineStart), .lineIdx(lineIdx),
        .pixEn(pixEn), .activeEn(activeEn),
        .txtRdEn(txtRdEn), .txtAddr(txtAddr), .txtData(txtData),
        .romRdEn(romRdEn), .romAddr(romAddr), .romData(romData),
        .outBit(outBit), .outValid(outValid), .underrun(underrun)
    );

    always #5 clock = ~clock;

    // Memory contents and read-port models (one clock read latency)
    logic [7:0] txt_mem [0:4095];
    logic [7:0] rom_mem [0:4095];

    always @(posedge clock) begin
        if (txtRdEn) txtData <= txt_mem[txtAddr];
        if (romRdEn) romData <= rom_mem[romAddr];
    end

    // Checking
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Per-line expectations and observations
    int   exp_txt [$];
    int   exp_rom [$];
    bit   exp_bits [$];
    int   n_txt, n_rom, n_ov;
    int   first_txt, first_rom, first_txt_cyc, first_rom_cyc, ls_cyc;
    int   cyc = 0;
    logic [7:0] obs8;

    task automatic clear_obs();
        exp_txt.delete();
        exp_rom.delete();
        exp_bits.delete();
        n_txt = 0; n_rom = 0; n_ov = 0;
        first_txt = -1; first_rom = -1; first_txt_cyc = -1; first_rom_cyc = -1;
        obs8 = 8'h00;
    endtask

    always @(posedge clock) begin
        bit e;
        #1;
        cyc++;
        if (txtRdEn) begin
            if (first_txt_cyc < 0) begin first_txt_cyc = cyc; first_txt = int'(txtAddr); end
            n_txt++;
            chk("rd_overlap", 32'(romRdEn), 32'd0);
            chk("txt_read_expected", 32'(exp_txt.size() != 0), 32'd1);
            if (exp_txt.size() != 0) chk("txtAddr", 32'(txtAddr), 32'(exp_txt.pop_front()));
        end
        if (romRdEn) begin
            if (first_rom_cyc < 0) begin first_rom_cyc = cyc; first_rom = int'(romAddr); end
            n_rom++;
            chk("rom_read_expected", 32'(exp_rom.size() != 0), 32'd1);
            if (exp_rom.size() != 0) chk("romAddr", 32'(romAddr), 32'(exp_rom.pop_front()));
        end
        if (outValid) begin
            e = (exp_bits.size() != 0) ? exp_bits.pop_front() : 1'b0;
            if (n_ov < 8) obs8[7 - n_ov] = outBit;
            n_ov++;
            chk("outBit", 32'(outBit), 32'(e));
        end
    end

    // Pulse lineStart and build the model of the line: the cells base..base+COLS-1 are read
    // in order, and the pixel stream is each glyph byte MSB first. `zeros` leading pixels are
    // expected dark (pixels consumed before the first cell can be ready).
    task automatic start_line(input int idx, input int zeros);
        int base;
        logic [3:0] g;
        logic [7:0] code;
        logic [7:0] gb;
        @(negedge clock);
        clear_obs();
        if (idx < LINES) begin
            base = (idx / GLYPH_H) * COLS;
            g    = 4'(idx % GLYPH_H);
            for (int z = 0; z < zeros; z++) exp_bits.push_back(1'b0);
            for (int c = 0; c < COLS; c++) begin
                code = txt_mem[base + c];
                exp_txt.push_back(base + c);
                exp_rom.push_back(int'({code, g}));
                gb = rom_mem[{code, g}];
                for (int b = 7; b >= 0; b--) exp_bits.push_back(gb[b]);
            end
        end
        ls_cyc    = cyc + 1;
        lineStart = 1'b1;
        lineIdx   = 9'(idx);
        pixEn     = 1'b0;
        activeEn  = 1'b0;
        @(negedge clock);
        lineStart = 1'b0;
    endtask

    // First pixel strobe is sampled `lead` clocks after the lineStart edge; later strobes
    // occur with probability rate%. Active pixels first, then inactive ones.
    task automatic drive_pixels(input int lead, input int rate, input int n_act, input int n_inact);
        int act = 0;
        int inact = 0;
        repeat (lead - 1) @(negedge clock);
        while (act < n_act || inact < n_inact) begin
            if ((act == 0 && inact == 0) || $urandom_range(1, 100) <= rate) begin
                pixEn = 1'b1;
                if (act < n_act) begin activeEn = 1'b1; act++; end
                else begin activeEn = 1'b0; inact++; end
            end else begin
                pixEn = 1'b0;
                activeEn = 1'b0;
            end
            @(negedge clock);
        end
        pixEn = 1'b0;
        activeEn = 1'b0;
    endtask

    task automatic end_line(input string nm, input int ov, input int reads, input logic und);
        repeat (3) @(negedge clock);
        chk({nm, "_outValid_count"}, 32'(n_ov), 32'(ov));
        chk({nm, "_txt_reads"}, 32'(n_txt), 32'(reads));
        chk({nm, "_rom_reads"}, 32'(n_rom), 32'(reads));
        chk({nm, "_underrun"}, 32'(underrun), 32'(und));
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_txtRdEn"},  32'(txtRdEn),  32'd0);
        chk({nm, "_txtAddr"},  32'(txtAddr),  32'd0);
        chk({nm, "_romRdEn"},  32'(romRdEn),  32'd0);
        chk({nm, "_romAddr"},  32'(romAddr),  32'd0);
        chk({nm, "_outBit"},   32'(outBit),   32'd0);
        chk({nm, "_outValid"}, 32'(outValid), 32'd0);
        chk({nm, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    initial begin
        int idx;
        reset = 1'b1; lineStart = 1'b0; lineIdx = '0; pixEn = 1'b0; activeEn = 1'b0;
        txtData = '0; romData = '0;
        for (int i = 0; i < 4096; i++) begin
            txt_mem[i] = 8'($urandom);
            rom_mem[i] = 8'($urandom);
        end
        // Directed contents: bit-order cell, and a stale/new pair for the abort case.
        txt_mem[0]            = 8'h41;
        rom_mem[{8'h41, 4'd3}] = 8'hA5;
        rom_mem[{8'h41, 4'd0}] = 8'hFF;
        txt_mem[80]           = 8'h22;
        rom_mem[{8'h22, 4'd0}] = 8'h00;
        clear_obs();

        repeat (2) @(negedge clock);
        chk_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Bit order and first cell, plus first-read timing
        start_line(3, 0);
        drive_pixels(8, 100, 8, 0);
        repeat (3) @(negedge clock);
        chk("bit_order", 32'(obs8), 32'h0000_00A5);
        chk("bit_order_count", 32'(n_ov), 32'd8);
        chk("bit_order_underrun", 32'(underrun), 32'd0);
        chk("txt_after_linestart", 32'(first_txt_cyc - ls_cyc), 32'd0);
        chk("rom_after_linestart", 32'(first_rom_cyc - ls_cyc), 32'd2);

        // Address formation on line 35
        start_line(35, 0);
        drive_pixels($urandom_range(6, 12), $urandom_range(30, 100), 640, 160);
        chk("addr_first_txt", 32'(first_txt), 32'd160);
        chk("addr_first_rom", 32'(first_rom), 32'(int'({txt_mem[160], 4'd3})));
        end_line("addr", 640, 80, 1'b0);

        // Full-rate line with the minimum lead
        start_line($urandom_range(0, LINES - 1), 0);
        drive_pixels(6, 100, 640, 160);
        end_line("fullrate", 640, 80, 1'b0);

        // Blank line
        start_line(480, 0);
        drive_pixels(6, $urandom_range(30, 100), 640, 160);
        end_line("blank", 640, 0, 1'b0);

        // Abort: second lineStart lands while line 0 is in ROM_LAT
        start_line(0, 0);
        repeat (2) @(negedge clock);
        start_line(16, 0);
        drive_pixels(6, $urandom_range(30, 100), 640, 160);
        chk("abort_first_txt", 32'(first_txt), 32'd80);
        chk("abort_first_byte", 32'(obs8), 32'd0);
        end_line("abort", 640, 80, 1'b0);

        // Random lines
        for (int n = 0; n < 6; n++) begin
            idx = $urandom_range(0, 511);
            start_line(idx, 0);
            drive_pixels($urandom_range(6, 12), $urandom_range(25, 100), 640, 160);
            end_line("random", 640, (idx < LINES) ? 80 : 0, 1'b0);
        end

        // Underrun: pixels start 2 clocks after lineStart; 4 pixels pass before the first cell
        start_line($urandom_range(0, LINES - 1), 4);
        drive_pixels(2, 100, 100, 0);
        chk("underrun_first4", 32'(obs8[7:4]), 32'd0);
        repeat (20) @(negedge clock);
        chk("underrun_set", 32'(underrun), 32'd1);
        drive_pixels(1, 100, 50, 0);
        chk("underrun_sticky", 32'(underrun), 32'd1);
        chk("pre_reset_outValid", 32'(outValid), 32'd1);

        // Asynchronous reset mid-line
        reset = 1'b1;
        clear_obs();
        #1;
        chk_outputs_zero("midline_reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("post_reset_txt_reads", 32'(n_txt), 32'd0);
        chk("post_reset_rom_reads", 32'(n_rom), 32'd0);
        chk("post_reset_outValid", 32'(n_ov), 32'd0);
        chk("post_reset_underrun", 32'(underrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/char_fetch_sequencer.md
# char_fetch_sequencer

Sequences text-mode glyph fetches for the VGA pixel path. On each line start, it walks the character cells of the current text row. For each cell it reads the character code from text RAM, then reads the matching glyph row byte from the character ROM. It serialises each glyph byte into one pixel bit per active pixel strobe, prefetching the next cell while the current one is being shifted out. It sits between the VGA timing generator and the text RAM / char ROM read ports.

## Interface
- COLS, 80, character cells per text row
- ROWS, 30, text rows per frame
- GLYPH_H, 16, glyph height in pixel lines (power of two; glyph row index = 4 bits)
- CODE_W, 8, character code width
- TXT_AW, 12, text RAM address width (must hold COLS*ROWS-1)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- lineStart  in  1  one-clock pulse; lineIdx valid this cycle
- lineIdx  in  9  pixel line number of the upcoming line
- pixEn  in  1  pixel strobe
- activeEn  in  1  high during active video
- txtRdEn  out  1  text RAM read strobe
- txtAddr  out  TXT_AW  text RAM address
- txtData  in  CODE_W  character code, valid exactly 1 clock after txtRdEn
- romRdEn  out  1  char ROM read strobe
- romAddr  out  CODE_W+4  {code, glyphRow}
- romData  in  8  glyph row byte (bit 7 = leftmost pixel), valid 1 clock after romRdEn
- outBit  out  1  registered pixel bit
- outValid  out  1  one-clock pulse per consumed active pixel
- underrun  out  1  sticky error flag, cleared only by reset

## Operation
- Line start latches the following:
  - textRow = lineIdx / GLYPH_H and glyphRow = lineIdx % GLYPH_H.
  - col = 0 and base = textRow*COLS.
  - curValid and nextValid are cleared.
- If lineIdx >= ROWS*GLYPH_H, the line is blank: no reads are issued.
- Fetch FSM states: IDLE, TXT_REQ, TXT_LAT, ROM_REQ, ROM_LAT, FULL.
  - IDLE: if lineStart on a non-blank line, go to TXT_REQ.
  - TXT_REQ: assert txtRdEn with txtAddr = base+col; go to TXT_LAT.
  - TXT_LAT: latch txtData into code; go to ROM_REQ.
  - ROM_REQ: assert romRdEn with romAddr = {code, glyphRow}; go to ROM_LAT.
  - ROM_LAT: latch romData into nextByte and set nextValid; go to FULL.
  - FULL: wait for nextValid to clear. Then, if col < COLS-1, increment col and go to TXT_REQ; otherwise go to IDLE.
- Shifter load rule: if nextValid and !curValid, load curByte <= nextByte, set curValid, reset bitCnt to 0, and clear nextValid. This is independent of pixEn.
- Pixel consume, on pixEn && activeEn:
  - outValid pulses and outBit <= curValid ? curByte[7-bitCnt] : 0.
  - If curValid, bitCnt increments.
  - At bitCnt == 7 the cell ends: reload from nextByte if nextValid (clearing nextValid); otherwise clear curValid.
- Underrun: set the sticky underrun flag when an active pixel is consumed with curValid = 0 while cells remain on the line. Cells remain when col has not passed COLS-1 or a fetch is pending. Exhausted cells and blank lines output 0 without flagging.
- lineStart while busy: a lineStart in any state aborts the current line. The in-flight read response is discarded, and the FSM restarts at TXT_REQ for the new line (or goes to IDLE if the new line is blank).

## Timing
- Reset values: all outputs 0, FSM in IDLE, curValid = nextValid = 0, col = 0.
- Read ports: exactly one strobe per cell read; strobes are single-cycle and never overlap.
- lineStart to first nextValid: 4 clocks. The first curValid follows 1 clock later.
- lineStart must precede the first active pixEn by at least 6 clocks; otherwise underrun.
- Fetch period is 5 clocks per cell. The shortest cell lasts 8 clocks (pixEn every clock), so no underrun can occur at any pixEn rate.
- Pixel latency: outBit/outValid are registered 1 clock after the consuming pixEn.
- Asynchronous reset mid-line returns everything to the reset values immediately. No reads are issued until the next lineStart.

## Test plan
- Bit order and first cell:
  - Stimulus: txt[0] = 0x41, rom[{0x41,3}] = 0xA5, lineIdx = 3, first pixEn 8 clocks later, 8 pixEn.
  - Required response: outBit sequence 1,0,1,0,0,1,0,1; underrun = 0.
- Address formation:
  - Stimulus: lineIdx = 35.
  - Required response: first txtAddr = 160, romAddr = {code, 4'd3}.
  - Stimulus: a full line.
  - Required response: txtAddr 160..239 in order, 80 text reads and 80 ROM reads.
- Full-rate line:
  - Stimulus: pixEn every clock for 640 active pixels, then 160 inactive pixels.
  - Required response: 640 outValid pulses; no reads after col 79; underrun = 0.
- Underrun:
  - Stimulus: lineStart only 2 clocks before the first active pixEn.
  - Required response: the first outBit values are 0 and underrun = 1, staying 1 until reset.
- Blank line:
  - Stimulus: lineIdx = 480.
  - Required response: zero txtRdEn/romRdEn; outBit = 0 on all active pixels; underrun stays 0.
- Abort and reset:
  - Stimulus: lineStart (lineIdx = 16) issued during ROM_LAT of line 0.
  - Required response: the next txtAddr is 80, and the stale byte never appears on outBit.
  - Stimulus: reset asserted mid-line.
  - Required response: all outputs return to 0 within the same cycle.
